// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared 2Kx8 dual-port block RAM.
// Requester A may read or write; requester B only reads. One operation per
// cycle is issued to the RAM, and read data returns to its issuer after a fixed
// latency of RD_LAT+2 cycles from acceptance.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic [ADDR_W-1:0] bram_rdaddr_o,
    output logic              bram_rden_o,
    output logic              bram_regce_o,
    output logic [ADDR_W-1:0] bram_wraddr_o,
    output logic [DATA_W-1:0] bram_di_o,
    output logic              bram_wren_o,
    input  logic [DATA_W-1:0] bram_do_i
);
    // Return pipeline spans the issue cycle plus the RAM read latency.
    localparam int unsigned Stages = RD_LAT + 1;

    typedef enum logic {OwnerB = 1'b0, OwnerA = 1'b1} owner_e;

    owner_e            last_q, last_d;
    logic              a_acc, b_acc, rd_acc;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d, wraddr_q, wraddr_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic              rden_q, rden_d, wren_q, wren_d, regce_q;
    logic [Stages-1:0] pv_q, pv_d;  // valid per return stage
    logic [Stages-1:0] pt_q, pt_d;  // tag per return stage, 1 = A
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    // Round-robin grant on a tie; grants are held off while reset is asserted.
    always_comb begin
        a_gnt_o = 1'b0;
        b_gnt_o = 1'b0;
        if (rst_ni) begin
            if (a_req_i && b_req_i) begin
                a_gnt_o = (last_q == OwnerB);
                b_gnt_o = (last_q == OwnerA);
            end else begin
                a_gnt_o = a_req_i;
                b_gnt_o = b_req_i;
            end
        end
    end

    assign a_acc  = a_req_i & a_gnt_o;
    assign b_acc  = b_req_i & b_gnt_o;
    assign rd_acc = (a_acc & ~a_we_i) | b_acc;

    // Next-state for the last-served owner, the issue stage and the return path.
    always_comb begin
        last_d   = last_q;
        rden_d   = 1'b0;
        wren_d   = 1'b0;
        rdaddr_d = rdaddr_q;
        wraddr_d = wraddr_q;
        di_d     = di_q;
        if (a_acc) begin
            last_d = OwnerA;
            if (a_we_i) begin
                wren_d   = 1'b1;
                wraddr_d = a_addr_i;
                di_d     = a_wdata_i;
            end else begin
                rden_d   = 1'b1;
                rdaddr_d = a_addr_i;
            end
        end else if (b_acc) begin
            last_d   = OwnerB;
            rden_d   = 1'b1;
            rdaddr_d = b_addr_i;
        end
        pv_d       = {pv_q[Stages-2:0], rd_acc};
        pt_d       = {pt_q[Stages-2:0], a_acc};
        a_rvalid_d = pv_q[Stages-1] & pt_q[Stages-1];
        b_rvalid_d = pv_q[Stages-1] & ~pt_q[Stages-1];
        a_rdata_d  = a_rvalid_d ? bram_do_i : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? bram_do_i : b_rdata_q;
    end

    // State registers; reset discards any reads still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= OwnerB;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            rdaddr_q   <= '0;
            wraddr_q   <= '0;
            di_q       <= '0;
            regce_q    <= 1'b0;
            pv_q       <= '0;
            pt_q       <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            last_q     <= last_d;
            rden_q     <= rden_d;
            wren_q     <= wren_d;
            rdaddr_q   <= rdaddr_d;
            wraddr_q   <= wraddr_d;
            di_q       <= di_d;
            regce_q    <= 1'b1;
            pv_q       <= pv_d;
            pt_q       <= pt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign bram_rdaddr_o = rdaddr_q;
    assign bram_rden_o   = rden_q;
    assign bram_regce_o  = regce_q;
    assign bram_wraddr_o = wraddr_q;
    assign bram_di_o     = di_q;
    assign bram_wren_o   = wren_q;
    assign a_rvalid_o    = a_rvalid_q;
    assign a_rdata_o     = a_rdata_q;
    assign b_rvalid_o    = b_rvalid_q;
    assign b_rdata_o     = b_rdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a behavioural RAM with registered output, and a
// transaction-level reference model (shadow memory plus a queue of expected
// read returns with due cycles) that predicts every output each cycle.
module tb_bram_port_arbiter;
    localparam int Aw  = 11;
    localparam int Dw  = 8;
    localparam int Lat = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
    logic [Aw-1:0] a_addr = '0, b_addr = '0;
    logic [Dw-1:0] a_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [Dw-1:0] a_rdata, b_rdata;
    logic [Aw-1:0] bram_rdaddr, bram_wraddr;
    logic          bram_rden, bram_regce, bram_wren;
    logic [Dw-1:0] bram_di, bram_do;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(Aw), .DATA_W(Dw), .RD_LAT(Lat)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_addr_i(b_addr), .b_gnt_o(b_gnt),
        .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .bram_rdaddr_o(bram_rdaddr), .bram_rden_o(bram_rden), .bram_regce_o(bram_regce),
        .bram_wraddr_o(bram_wraddr), .bram_di_o(bram_di), .bram_wren_o(bram_wren),
        .bram_do_i(bram_do)
    );

    // Block RAM: array read on RDEN, then output register on REGCE.
    logic [Dw-1:0] ram [0:2047];
    logic [Dw-1:0] ram_arr_q, ram_do_q;
    always @(posedge clk) begin
        if (bram_wren) ram[bram_wraddr] <= bram_di;
        if (bram_rden) ram_arr_q <= ram[bram_rdaddr];
        if (bram_regce) ram_do_q <= ram_arr_q;
    end
    assign bram_do = ram_do_q;

    // Reference model
    typedef struct {
        int            due;
        bit            tag_a;
        logic [Dw-1:0] data;
    } ret_t;
    ret_t          rq[$];
    logic [Dw-1:0] mem_m [0:2047];
    bit            m_last_a;
    int            cyc = 0;
    logic          e_agnt, e_bgnt, e_arv, e_brv, e_rden, e_wren, e_regce;
    logic [Dw-1:0] e_ardata, e_brdata, e_di;
    logic [Aw-1:0] e_rdaddr, e_wraddr;

    task automatic model_reset();
        m_last_a = 1'b0;
        rq.delete();
        e_arv = 0; e_brv = 0; e_rden = 0; e_wren = 0; e_regce = 0;
        e_ardata = '0; e_brdata = '0; e_di = '0; e_rdaddr = '0; e_wraddr = '0;
    endtask

    // Predict this cycle's outputs; samples at the falling edge.
    task automatic model_eval();
        @(negedge clk);
        e_arv = 1'b0;
        e_brv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].tag_a) begin e_arv = 1'b1; e_ardata = rq[0].data; end
            else begin e_brv = 1'b1; e_brdata = rq[0].data; end
            void'(rq.pop_front());
        end
        e_agnt = 1'b0;
        e_bgnt = 1'b0;
        if (rst_n) begin
            if (a_req && b_req) begin
                if (m_last_a) e_bgnt = 1'b1; else e_agnt = 1'b1;
            end else begin
                e_agnt = a_req;
                e_bgnt = b_req;
            end
        end
    endtask

    // Apply this cycle's acceptance, then move past the next rising edge.
    task automatic model_advance();
        e_rden = 1'b0;
        e_wren = 1'b0;
        if (rst_n) begin
            e_regce = 1'b1;
            if (e_agnt) begin
                m_last_a = 1'b1;
                if (a_we) begin
                    e_wren = 1'b1; e_wraddr = a_addr; e_di = a_wdata;
                    mem_m[a_addr] = a_wdata;
                end else begin
                    e_rden = 1'b1; e_rdaddr = a_addr;
                    rq.push_back('{cyc + 2 + Lat, 1'b1, mem_m[a_addr]});
                end
            end else if (e_bgnt) begin
                m_last_a = 1'b0;
                e_rden = 1'b1; e_rdaddr = b_addr;
                rq.push_back('{cyc + 2 + Lat, 1'b0, mem_m[b_addr]});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [52:0] obs_vec();
        return {a_gnt, b_gnt, a_rvalid, a_rdata, b_rvalid, b_rdata, bram_rden, bram_rdaddr,
                bram_wren, bram_wraddr, bram_di, bram_regce};
    endfunction

    function automatic logic [52:0] exp_vec();
        return {e_agnt, e_bgnt, e_arv, e_ardata, e_brv, e_brdata, e_rden, e_rdaddr,
                e_wren, e_wraddr, e_di, e_regce};
    endfunction

    task automatic apply_reset();
        a_req = 0; b_req = 0;
        rst_n = 0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; cyc++; end
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            a_req = 1'($urandom); a_we = 1'($urandom); b_req = 1'($urandom);
            a_addr = 11'($urandom); b_addr = 11'($urandom); a_wdata = 8'($urandom);
            model_eval();
            n_run++;
            if (obs_vec() !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d got=%h exp=0", k, obs_vec());
            end
            model_advance();
        end
        a_req = 0; b_req = 0; rst_n = 1;
        model_eval();
        n_run++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL release_cycle got=%h exp=%h", obs_vec(), exp_vec());
        end
        model_advance();
        model_eval();
        n_run++;
        if (bram_regce !== 1'b1) begin
            n_fail++;
            $display("FAIL regce_after_release got=%b exp=1", bram_regce);
        end
        model_advance();
    endtask

    task automatic test_preload();
        for (int k = 0; k < 38; k++) begin
            a_req = (k < 32); a_we = 1'b1; a_addr = 11'(k); a_wdata = 8'($urandom);
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL preload k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            model_advance();
        end
        a_req = 0;
    endtask

    task automatic test_write_then_read();
        for (int k = 0; k < 8; k++) begin
            a_req = (k == 0); a_we = 1'b1; a_addr = 11'h005; a_wdata = 8'hA5;
            b_req = (k == 1); b_addr = 11'h005;
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wr_rd k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            n_run++;
            if (bram_wren !== (k == 1) || bram_rden !== (k == 2) || a_rvalid !== 1'b0
                || b_rvalid !== (k == 5) || (k == 5 && b_rdata !== 8'hA5)) begin
                n_fail++;
                $display("FAIL wr_rd_timing k=%0d got wren=%b rden=%b arv=%b brv=%b brd=%h",
                         k, bram_wren, bram_rden, a_rvalid, b_rvalid, b_rdata);
            end
            model_advance();
        end
        a_req = 0; b_req = 0;
    endtask

    task automatic test_tie();
        int rden_cnt;
        rden_cnt = 0;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            a_req = (k < 6); b_req = (k < 6); a_we = 1'b0;
            a_addr = 11'($urandom_range(0, 31)); b_addr = 11'($urandom_range(0, 31));
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL tie k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (k < 6) begin
                n_run++;
                if (a_gnt !== ((k % 2) == 0) || b_gnt !== ((k % 2) == 1)) begin
                    n_fail++;
                    $display("FAIL tie_order k=%0d got a=%b b=%b exp a=%b", k, a_gnt, b_gnt,
                             (k % 2) == 0);
                end
            end
            if (bram_rden === 1'b1) rden_cnt++;
            n_run++;
            if (a_rvalid !== (k >= 4 && k < 10 && (k % 2) == 0)
                || b_rvalid !== (k >= 4 && k < 10 && (k % 2) == 1)) begin
                n_fail++;
                $display("FAIL tie_rvalid_tag k=%0d got a=%b b=%b", k, a_rvalid, b_rvalid);
            end
            model_advance();
        end
        n_run++;
        if (rden_cnt !== 6) begin
            n_fail++;
            $display("FAIL tie_rden_count got=%0d exp=6", rden_cnt);
        end
        a_req = 0; b_req = 0;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 22; k++) begin
            b_req = (k < 16); b_addr = 11'(k); a_req = 1'b0;
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            n_run++;
            if (b_rvalid !== (k >= 4 && k < 20) || (k < 16 && b_gnt !== 1'b1)) begin
                n_fail++;
                $display("FAIL stream_pulses k=%0d got brv=%b bgnt=%b", k, b_rvalid, b_gnt);
            end
            model_advance();
        end
        b_req = 0;
    endtask

    task automatic test_reset_midflight();
        int late_rv;
        late_rv = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 3) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 11'(k); b_req = 1'b0;
            end else if (k < 6) begin
                if (k == 3) begin rst_n = 0; model_reset(); end
                a_req = 1'($urandom); b_req = 1'($urandom); a_we = 1'b0;
            end else begin
                rst_n = 1; a_req = 0; b_req = 0;
            end
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL midflight k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (k >= 3 && (a_rvalid !== 1'b0 || b_rvalid !== 1'b0)) late_rv++;
            model_advance();
        end
        n_run++;
        if (late_rv !== 0) begin
            n_fail++;
            $display("FAIL midflight_rvalid got=%0d pulses exp=0", late_rv);
        end
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; a_addr = 11'd1; b_addr = 11'd2;
        model_eval();
        n_run++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_first_tie got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt);
        end
        model_advance();
        a_req = 0; b_req = 0;
        for (int k = 0; k < 6; k++) begin
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL midflight_drain k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            model_advance();
        end
    endtask

    task automatic test_rdata_hold();
        for (int k = 0; k < 16; k++) begin
            a_req = (k < 2); a_we = (k == 0); a_addr = 11'h007; a_wdata = 8'h3C;
            b_req = (k >= 6); b_addr = 11'($urandom_range(0, 31));
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (k >= 5) begin
                n_run++;
                if (a_rdata !== 8'h3C || a_rvalid !== (k == 5)) begin
                    n_fail++;
                    $display("FAIL hold_a_rdata k=%0d got=%h/%b exp=3c/%b", k, a_rdata,
                             a_rvalid, k == 5);
                end
            end
            model_advance();
        end
        a_req = 0; b_req = 0;
    endtask

    task automatic test_random();
        bit acc_a, acc_b;
        for (int k = 0; k < 306; k++) begin
            model_eval();
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            acc_a = e_agnt;
            acc_b = e_bgnt;
            model_advance();
            if (acc_a || !a_req) begin
                a_req = (k < 300) && ($urandom_range(0, 3) != 0);
                a_we = 1'($urandom); a_addr = 11'($urandom_range(0, 31)); a_wdata = 8'($urandom);
            end
            if (acc_b || !b_req) begin
                b_req = (k < 300) && ($urandom_range(0, 3) != 0);
                b_addr = 11'($urandom_range(0, 31));
            end
        end
        a_req = 0; b_req = 0;
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_then_read();
        test_tie();
        test_stream();
        test_reset_midflight();
        test_rdata_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
